uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_PER_HALF_BIT, default 30, clock cycles per half UART bit period; one bit period is 2*CLK_PER_HALF_BIT cycles.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rxd  input  1  serial line, idle high, 8N1 framing (start 0, 8 data bits LSB first, 1 stop bit 1).
REQ-005 rdata  output  8  last correctly received byte; held until the next good frame.
REQ-006 rx_ready  output  1  one-cycle pulse; rdata is valid in the same cycle and holds its value afterwards.
REQ-007 ferr  output  1  one-cycle pulse on framing error, where the sampled stop bit is 0.
REQ-008 rx_busy  output  1  high in every state except IDLE.

Function
REQ-009 Input stage SHALL register rxd into an internal sampled line rxs; the register depth is set by Configuration.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-011 A 32-bit cycle counter SHALL be cleared on every state entry and after every bit sample.
REQ-012 IDLE: when rxs=0, the block SHALL go to START with counter=0; otherwise it remains in IDLE.
REQ-013 START: at counter=CLK_PER_HALF_BIT-1, if rxs=1 the low pulse is treated as a glitch and the FSM SHALL return to IDLE with no output pulse; else it SHALL go to DATA with counter=0.
REQ-014 DATA: at each counter=2*CLK_PER_HALF_BIT-1 the FSM SHALL shift rxs into the MSB of the shift register (right shift) and clear the counter; after the 8th sample it SHALL go to STOP.
REQ-015 STOP: at counter=2*CLK_PER_HALF_BIT-1, if rxs=1 then the next cycle SHALL have rdata=shift register, rx_ready=1 and state IDLE.
REQ-016 STOP: at counter=2*CLK_PER_HALF_BIT-1, if rxs=0 then the next cycle SHALL have ferr=1, rdata unchanged and state BREAK.
REQ-017 BREAK SHALL wait for rxs=1 and then go to IDLE, so a held-low line produces exactly one ferr and no further frames.
REQ-018 rx_ready and ferr SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-019 Latency: with t0 defined as the first cycle rxs=0 in IDLE, rx_ready or ferr SHALL be high at cycle t0+1+CLK_PER_HALF_BIT+9*2*CLK_PER_HALF_BIT (t0+571 for the default).
REQ-020 A new start bit SHALL be accepted in the first IDLE cycle after rx_ready, supporting back-to-back frames with no idle gap.
REQ-021 The block has no consumer backpressure; a new good frame overwrites rdata unconditionally.

Reset
REQ-022 reset SHALL force: state=IDLE, counter=0, shift register=0, rdata=8'h00, rx_ready=0, ferr=0, rx_busy=0, and all input stage flops=1.
REQ-023 reset asserted mid-frame SHALL abandon the frame with no rx_ready or ferr pulse.
REQ-024 After reset deassertion the block SHALL stay in IDLE until rxs reads 0; a line that is low at deassertion is treated as a start bit.

Configuration
REQ-025 Macro UART_RX_SYNC_EN defined: the input stage SHALL be a two-flop synchronizer, so rxs lags rxd by 2 cycles.
REQ-026 Macro UART_RX_SYNC_EN undefined: the input stage SHALL be one flop, so rxs lags rxd by 1 cycle.
REQ-027 No other behaviour SHALL differ between the two configurations.

Verification (CLK_PER_HALF_BIT=30)
REQ-028 Drive frame 0x55 with ideal 60-cycle bits -> one rx_ready pulse, rdata=8'h55, ferr never high, rx_ready at t0+571.
REQ-029 Drive 0xA3 then 0x0F back-to-back with no gap -> two rx_ready pulses 600 cycles apart, with rdata=8'hA3 then 8'h0F.
REQ-030 Drive a 20-cycle low glitch on idle rxd -> no rx_ready, no ferr, rx_busy returns low within 32 cycles.
REQ-031 Drive frame 0x3C with stop bit 0, then hold rxd low for 2000 cycles -> exactly one ferr pulse, rdata keeps its previous value, and rx_busy stays high until rxd returns high.
REQ-032 Assert reset for 1 cycle in the middle of data bit 4 of frame 0xFF -> no pulse, rdata=8'h00; the next 0x81 frame is received correctly.
REQ-033 Run REQ-028 with UART_RX_SYNC_EN defined and undefined -> identical rdata, with the rx_ready time relative to the rxd falling edge differing by exactly 1 cycle.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with glitch rejection, framing-error pulse and break hold-off.
// Define UART_RX_SYNC_EN for a two-flop input synchronizer (default: one flop).
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [31:0] HALF_M1 = 32'(CLK_PER_HALF_BIT - 1);
    localparam logic [31:0] FULL_M1 = 32'(2 * CLK_PER_HALF_BIT - 1);

    logic rxs;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clock) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rxd};
    end

    assign rxs = sync[1];
`else
    logic sync;

    always_ff @(posedge clock) begin
        if (reset) sync <= 1'b1;
        else       sync <= rxd;
    end

    assign rxs = sync;
`endif

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rdata    <= 8'h00;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        // Line back high at mid start bit: treat as glitch.
                        if (rxs) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            rdata    <= shreg;
                            rx_ready <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a frame-level model.
// Pulse timing is measured from the cycle the bench drives rxd low.
module tb_uart_rx;

    localparam int H   = 30;
    localparam int BIT = 2 * H;
`ifdef UART_RX_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif
    localparam int LAT = LAG + 1 + H + 18 * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rdata;
    logic       rx_ready;
    logic       ferr;
    logic       rx_busy;

    uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_ready (rx_ready),
        .ferr     (ferr),
        .rx_busy  (rx_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    int         rdy_t[$];
    logic [7:0] rdy_d[$];
    int         ferr_t[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clock) begin
        if (rx_ready) begin
            rdy_t.push_back(cyc);
            rdy_d.push_back(rdata);
        end
        if (ferr) ferr_t.push_back(cyc);
        if (rx_ready || ferr) check("pulse_excl", 32'(rx_ready & ferr), 0);
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_log();
        rdy_t.delete();
        rdy_d.delete();
        ferr_t.delete();
    endtask

    task automatic send(logic [7:0] b, logic stop, output int fall);
        rxd  = 1'b0;
        fall = cyc;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BIT);
        end
        rxd = stop;
        tick(BIT);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int         f0, f1;
    int         gap;
    logic [7:0] b;
    logic [7:0] exp_d[$];
    int         exp_t[$];

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_busy", 32'(rx_busy), 0);

        // single frame 0x55
        clear_log();
        send(8'h55, 1'b1, f0);
        tick(10);
        check("f55_count", 32'(rdy_t.size()), 1);
        if (rdy_t.size() == 1) begin
            check("f55_data", 32'(rdy_d[0]), 32'h55);
            check("f55_time", 32'(rdy_t[0] - f0), 32'(LAT));
        end
        check("f55_noferr", 32'(ferr_t.size()), 0);

        // back-to-back frames
        clear_log();
        send(8'hA3, 1'b1, f0);
        send(8'h0F, 1'b1, f1);
        tick(10);
        check("b2b_count", 32'(rdy_t.size()), 2);
        if (rdy_t.size() == 2) begin
            check("b2b_d0", 32'(rdy_d[0]), 32'hA3);
            check("b2b_d1", 32'(rdy_d[1]), 32'h0F);
            check("b2b_t0", 32'(rdy_t[0] - f0), 32'(LAT));
            check("b2b_gap", 32'(rdy_t[1] - rdy_t[0]), 32'(2 * BIT * 5));
        end
        check("b2b_rdata_hold", 32'(rdata), 32'h0F);

        // 20-cycle glitch
        clear_log();
        rxd = 1'b0;
        tick(20);
        rxd = 1'b1;
        check("gl_busy_hi", 32'(rx_busy), 1);
        tick(20);
        check("gl_busy_lo", 32'(rx_busy), 0);
        tick(BIT);
        check("gl_noready", 32'(rdy_t.size()), 0);
        check("gl_noferr", 32'(ferr_t.size()), 0);

        // framing error then long break
        clear_log();
        send(8'h3C, 1'b0, f0);
        tick(2000);
        check("fe_busy_brk", 32'(rx_busy), 1);
        rxd = 1'b1;
        tick(5);
        check("fe_busy_lo", 32'(rx_busy), 0);
        check("fe_count", 32'(ferr_t.size()), 1);
        if (ferr_t.size() == 1)
            check("fe_time", 32'(ferr_t[0] - f0), 32'(LAT));
        check("fe_noready", 32'(rdy_t.size()), 0);
        check("fe_rdata", 32'(rdata), 32'h0F);

        // reset in the middle of data bit 4 of 0xFF
        clear_log();
        rxd = 1'b0;
        tick(BIT);
        rxd = 1'b1;
        tick(4 * BIT + H);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5 * BIT);
        check("rm_noready", 32'(rdy_t.size()), 0);
        check("rm_noferr", 32'(ferr_t.size()), 0);
        check("rm_rdata", 32'(rdata), 32'h00);
        check("rm_busy", 32'(rx_busy), 0);
        send(8'h81, 1'b1, f0);
        tick(5);
        check("rm_81_count", 32'(rdy_t.size()), 1);
        if (rdy_t.size() == 1) begin
            check("rm_81_data", 32'(rdy_d[0]), 32'h81);
            check("rm_81_time", 32'(rdy_t[0] - f0), 32'(LAT));
        end

        // random frames with random idle gaps
        clear_log();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send(b, 1'b1, f0);
            exp_d.push_back(b);
            exp_t.push_back(f0 + LAT);
            gap = $urandom_range(0, 40);
            tick(gap);
        end
        tick(20);
        check("rnd_count", 32'(rdy_t.size()), 32'(exp_d.size()));
        if (rdy_t.size() == exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                check($sformatf("rnd_d%0d", i), 32'(rdy_d[i]), 32'(exp_d[i]));
                check($sformatf("rnd_t%0d", i), 32'(rdy_t[i]), 32'(exp_t[i]));
            end
        end
        check("rnd_noferr", 32'(ferr_t.size()), 0);
        check("rnd_last", 32'(rdata), 32'(exp_d[exp_d.size() - 1]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
